// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding RV32I load/store unit over a local data memory.
//
// Accepts one request at a time (valid/ready), waits LATENCY cycles, then
// presents a response (valid/ready) holding the load result or an error flag.
// Stores commit, and loads read the memory, on the edge that enters RESP.
//
// State table
//   IDLE | ready for a new request (req_ready=1 unless rst is high)
//   WAIT | request latched, counting down the configured latency
//   RESP | response presented, held until the consumer takes it
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_funct3            store/load select and RV32I size/sign code
//   req_addr, req_wdata           byte address and right-aligned store data
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            load result (0 for stores/errors), error flag
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Not cleared by reset: contents survive a reset pulse.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [AW-1:0] word_idx;
  logic [1:0]  lane;
  logic [31:0] rd_word;
  logic [3:0]  byte_en;
  logic [31:0] wr_lanes;
  logic [31:0] wr_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With LATENCY=0 the commit happens on the accepting edge itself, before the
  // request registers hold anything, so the datapath looks at the live inputs
  // while in IDLE and at the latched copy otherwise.
  assign cur_we     = (state_q == ST_IDLE) ? req_we     : we_q;
  assign cur_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
  assign cur_addr   = (state_q == ST_IDLE) ? req_addr   : addr_q;
  assign cur_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

  assign commit = ((state_q == ST_IDLE) && accept && (LATENCY == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd0));

  assign word_idx = cur_addr[AW+1:2];
  assign lane     = cur_addr[1:0];
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    cur_err = 1'b0;
    case (cur_funct3)
      3'b000, 3'b100: cur_err = 1'b0;
      3'b001, 3'b101: cur_err = cur_addr[0];
      3'b010:         cur_err = (cur_addr[1:0] != 2'b00);
      default:        cur_err = 1'b1;
    endcase
    // Stores only have sb/sh/sw; the unsigned load codes are illegal for them.
    if (cur_we && cur_funct3[2]) cur_err = 1'b1;
    if (cur_addr[31:2] >= 30'(DEPTH_WORDS)) cur_err = 1'b1;
  end

  always_comb begin
    byte_en  = 4'b1111;
    wr_lanes = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = cur_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = byte_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    rd_byte  = 8'(rd_word >> {lane, 3'b000});
    rd_half  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = 32'h0;
    case (cur_funct3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_val = {24'h0, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_val = {16'h0, rd_half};
      3'b010:  load_val = rd_word;
      default: load_val = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (commit) begin
        err_q   <= cur_err;
        rdata_q <= (cur_err || cur_we) ? 32'h0 : load_val;
      end
    end
  end

  // commit already implies rst is low (no WAIT under reset, no accept with rst
  // high), so an abandoned store never reaches this write.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_err) mem_q[word_idx] <= wr_word;
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory depth in 32-bit words (power of 2, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 1, wait cycles between accept and response (0..15).
REQ-003 SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  block can accept a request.
REQ-007 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  in  3  RV32I size/sign code.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-013 SHALL have port rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  out  1  request was rejected.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE with rst low.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, and latch we, funct3, addr and wdata.
- Request inputs are ignored outside the accepting edge.
REQ-018 SHALL, on accept, go to WAIT with counter=LATENCY-1 when LATENCY>0, else go directly to RESP.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
- Accept at edge N gives rsp_valid=1 from cycle N+1+LATENCY.
REQ-020 SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err in RESP until an edge with rsp_ready=1, then return to IDLE.
- Back-to-back rate: one request per LATENCY+2 cycles.
REQ-021 SHALL drive rsp_valid=0, rsp_rdata=0 and rsp_err=0 outside RESP.
REQ-022 SHALL select word index addr[2+log2(DEPTH_WORDS)-1:2] and byte lane addr[1:0].
REQ-023 SHALL flag an error for any of:
- store funct3 not in {000,001,010};
- load funct3 not in {000,001,010,100,101};
- halfword access with addr[0]=1;
- word access with addr[1:0]!=0;
- addr[31:2] >= DEPTH_WORDS.
REQ-024 SHALL, on error, perform no memory write, return rsp_err=1 and return rsp_rdata=0.
REQ-025 SHALL commit a valid store on the edge entering RESP, writing only the addressed lanes:
- sb: 1 lane, wdata[7:0];
- sh: lanes addr[1]*2 and +1, wdata[15:0];
- sw: all 4 lanes;
- other bytes in the word unchanged.
REQ-026 SHALL form a load result from the memory word read on the edge entering RESP:
- lb/lh: sign-extended;
- lbu/lhu: zero-extended;
- lw: unchanged.
REQ-027 SHALL make a load issued after a store's response is accepted return the stored data (no stale read).
REQ-028 SHALL initialise all memory words to 0 at time zero.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 SHALL abandon a transaction in WAIT or RESP on reset; a store not yet committed SHALL NOT write.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL assert req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: LATENCY=1; sw 0xDEADBEEF @0x10; then lw @0x10 -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-034 SHALL cover: after REQ-033, sb 0x7F @0x11 then lb @0x11 -> 0x0000007F; sh 0x8001 @0x12 then lh @0x12 -> 0xFFFF8001, lhu -> 0x00008001, lw @0x10 -> 0x80017FEF.
REQ-035 SHALL cover: sh @0x13, lw @0x22 and funct3=011 store -> rsp_err=1 and rdata=0; memory unchanged on readback.
REQ-036 SHALL cover: DEPTH_WORDS=1024, lw @0x1000 -> rsp_err=1; lw @0xFFC -> err=0.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: LATENCY=3; sw 0x12345678 @0x40; rst pulsed in WAIT -> outputs 0 immediately, and lw @0x40 after reset returns the prior value (0).
